// File: rtl/mont_pkg.sv
// Shared types and defaults for the modular exponentiation controller and its
// Montgomery multiplier interface.
package mont_pkg;

    localparam int unsigned N_DEF   = 1024;
    localparam int unsigned E_W_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TO_MONT,
        ST_SCAN,
        ST_SQUARE,
        ST_MULTIPLY,
        ST_FROM_MONT,
        ST_DONE
    } state_e;

    // Bit counter must hold E_W itself, not just E_W-1.
    function automatic int unsigned cnt_width(input int unsigned e_w);
        return $clog2(e_w + 1);
    endfunction

endpackage

// File: rtl/mont_modexp_ctrl_if.sv
// Start/done operand bus between the exponentiation controller (master) and
// the Montgomery multiplier (slave).
interface mont_modexp_ctrl_if #(
    parameter int unsigned N = mont_pkg::N_DEF
);
    logic         mm_start;
    logic [N-1:0] mm_a;
    logic [N-1:0] mm_b;
    logic [N-1:0] mm_m;
    logic [N-1:0] mm_result;
    logic         mm_done;

    modport master (
        output mm_start, mm_a, mm_b, mm_m,
        input  mm_result, mm_done
    );

    modport slave (
        input  mm_start, mm_a, mm_b, mm_m,
        output mm_result, mm_done
    );
endinterface

// File: rtl/mont_modexp_ctrl_exp_bit_scanner.sv
// Exponent shift register with a down-counter of bits still to consume;
// msb is the bit under examination, last flags the final bit.
module exp_bit_scanner
    import mont_pkg::*;
#(
    parameter int unsigned E_W = E_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic           shift_i,
    input  logic [E_W-1:0] e_i,
    output logic           msb_o,
    output logic           last_o
);
    localparam int unsigned CW = cnt_width(E_W);

    logic [E_W-1:0] e_q;
    logic [CW-1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            e_q   <= e_i;
            cnt_q <= CW'(E_W);
        end else if (shift_i && (cnt_q != '0)) begin
            e_q   <= e_q << 1;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign msb_o  = e_q[E_W-1];
    assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right binary modular exponentiation controller driving an external
// Montgomery multiplier over a start/done bus: result = x^e mod M.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for start; operands latched on accept
// ST_TO_MONT   | xm = mont(x, R^2)
// ST_SCAN      | skip leading zero exponent bits, A = xm at the top set bit
// ST_SQUARE    | A = mont(A, A)
// ST_MULTIPLY  | A = mont(A, xm)
// ST_FROM_MONT | result = mont(A, 1)
// ST_DONE      | one-cycle done pulse
module mont_modexp_ctrl
    import mont_pkg::*;
#(
    parameter int unsigned N   = N_DEF,
    parameter int unsigned E_W = E_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N-1:0]              in_x,
    input  logic [E_W-1:0]            in_e,
    input  logic [N-1:0]              in_m,
    input  logic [N-1:0]              in_r,
    input  logic [N-1:0]              in_r2,
    output logic [N-1:0]              result,
    output logic                      done,
    output logic                      busy,
    mont_modexp_ctrl_if.master        mm
);
    state_e       state_q, state_d;
    logic [N-1:0] x_q, x_d, m_q, m_d, r_q, r_d, r2_q, r2_d;
    logic [N-1:0] xm_q, xm_d, a_q, a_d, result_q, result_d;
    logic [N-1:0] mm_a_q, mm_a_d, mm_b_q, mm_b_d;
    logic [N-1:0] op_a, op_b;
    logic         mm_start_q, mm_start_d, issued_q, issued_d;
    logic         mult_st, mm_fire;
    logic         load, shift, msb, last;

    exp_bit_scanner #(.E_W(E_W)) u_scanner (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (shift),
        .e_i     (in_e),
        .msb_o   (msb),
        .last_o  (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            m_q        <= '0;
            r_q        <= '0;
            r2_q       <= '0;
            xm_q       <= '0;
            a_q        <= '0;
            result_q   <= '0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mm_start_q <= 1'b0;
            issued_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            m_q        <= m_d;
            r_q        <= r_d;
            r2_q       <= r2_d;
            xm_q       <= xm_d;
            a_q        <= a_d;
            result_q   <= result_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            mm_start_q <= mm_start_d;
            issued_q   <= issued_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        m_d        = m_q;
        r_d        = r_q;
        r2_d       = r2_q;
        xm_d       = xm_q;
        a_d        = a_q;
        result_d   = result_q;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;
        mm_start_d = 1'b0;
        issued_d   = issued_q;
        load       = 1'b0;
        shift      = 1'b0;
        done       = 1'b0;
        op_a       = '0;
        op_b       = '0;
        mult_st    = 1'b1;

        unique case (state_q)
            ST_TO_MONT:   begin op_a = x_q; op_b = r2_q; end
            ST_SQUARE:    begin op_a = a_q; op_b = a_q;  end
            ST_MULTIPLY:  begin op_a = a_q; op_b = xm_q; end
            ST_FROM_MONT: begin op_a = a_q; op_b = {{(N-1){1'b0}}, 1'b1}; end
            default:      mult_st = 1'b0;
        endcase

        // First cycle of a multiply state issues; later cycles wait for done.
        mm_fire = mult_st && issued_q && mm.mm_done;
        if (mult_st && !issued_q) begin
            mm_start_d = 1'b1;
            mm_a_d     = op_a;
            mm_b_d     = op_b;
            issued_d   = 1'b1;
        end else if (mm_fire) begin
            issued_d   = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = in_x;
                    m_d     = in_m;
                    r_d     = in_r;
                    r2_d    = in_r2;
                    load    = 1'b1;
                    state_d = ST_TO_MONT;
                end
            end
            ST_TO_MONT: begin
                if (mm_fire) begin
                    xm_d    = mm.mm_result;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                shift = 1'b1;
                if (msb) begin
                    a_d     = xm_q;
                    state_d = last ? ST_FROM_MONT : ST_SQUARE;
                end else if (last) begin
                    a_d     = r_q;
                    state_d = ST_FROM_MONT;
                end
            end
            ST_SQUARE: begin
                if (mm_fire) begin
                    a_d = mm.mm_result;
                    if (msb) begin
                        state_d = ST_MULTIPLY;
                    end else begin
                        shift   = 1'b1;
                        state_d = last ? ST_FROM_MONT : ST_SQUARE;
                    end
                end
            end
            ST_MULTIPLY: begin
                if (mm_fire) begin
                    a_d     = mm.mm_result;
                    shift   = 1'b1;
                    state_d = last ? ST_FROM_MONT : ST_SQUARE;
                end
            end
            ST_FROM_MONT: begin
                if (mm_fire) begin
                    result_d = mm.mm_result;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign result      = result_q;
    assign mm.mm_start = mm_start_q;
    assign mm.mm_a     = mm_a_q;
    assign mm.mm_b     = mm_b_q;
    assign mm.mm_m     = m_q;

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Scoreboard bench for mont_modexp_ctrl with a behavioural Montgomery
// multiplier of programmable latency.
module tb_mont_modexp_ctrl;
    localparam int unsigned N   = 1024;
    localparam int unsigned E_W = 1024;
    localparam logic [N-1:0] M  = 3233;

    typedef struct {
        logic [N-1:0] res;
        int           mults;
        int           lat;
        int           acc;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [N-1:0]   in_x, in_m, in_r, in_r2;
    logic [E_W-1:0] in_e;
    logic [N-1:0]   result;
    logic           done, busy;

    int   nchk, npass, ndone, mm_starts;
    int   cyc = 0;
    int   lm;
    int   rem;
    logic stray;
    logic [N-1:0] prod;
    exp_t sb[$];

    mont_modexp_ctrl_if #(.N(N)) mm_bus ();

    mont_modexp_ctrl #(.N(N), .E_W(E_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in_x   (in_x),
        .in_e   (in_e),
        .in_m   (in_m),
        .in_r   (in_r),
        .in_r2  (in_r2),
        .result (result),
        .done   (done),
        .busy   (busy),
        .mm     (mm_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] mont(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [N-1:0] m);
        logic [N+1:0] t;
        t = '0;
        for (int i = 0; i < N; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[N-1:0];
    endfunction

    function automatic logic [N-1:0] pow2_mod(input int k, input logic [N-1:0] m);
        logic [N:0] r;
        r = 1;
        for (int i = 0; i < k; i++) begin
            r = r << 1;
            if (r >= {1'b0, m}) r = r - {1'b0, m};
        end
        return r[N-1:0];
    endfunction

    function automatic int scan_cycles(input logic [E_W-1:0] e);
        for (int i = E_W - 1; i >= 0; i--)
            if (e[i]) return E_W - i;
        return E_W;
    endfunction

    // Multiplier model: done arrives lm cycles after start, counting both ends.
    always @(negedge clk)
        if (mm_bus.mm_start) prod <= mont(mm_bus.mm_a, mm_bus.mm_b, mm_bus.mm_m);

    always @(posedge clk) begin
        if (reset)                rem <= 0;
        else if (mm_bus.mm_start) rem <= lm - 1;
        else if (rem > 0)         rem <= rem - 1;
    end

    assign mm_bus.mm_done   = stray | (mm_bus.mm_start && lm == 1) | (rem == 1);
    assign mm_bus.mm_result = prod;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act[63:0], exp[63:0]);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic monitor();
        exp_t ent;
        forever begin
            @(negedge clk);
            if (reset) begin
                mm_starts = 0;
            end else begin
                if (mm_bus.mm_start) mm_starts++;
                if (done) begin
                    if (sb.size() == 0) begin
                        nchk++;
                        $display("FAIL unexpected_done: got done=1 expected no done");
                    end else begin
                        ent = sb.pop_front();
                        chk("result", result, ent.res);
                        chk_int("mm_start_count", mm_starts, ent.mults);
                        chk_int("latency", cyc - ent.acc, ent.lat);
                    end
                    mm_starts = 0;
                    ndone++;
                end
            end
        end
    endtask

    task automatic drive_op(input logic [N-1:0] x, input logic [E_W-1:0] e);
        in_x  = x;
        in_e  = e;
        in_m  = M;
        in_r  = pow2_mod(N, M);
        in_r2 = pow2_mod(2 * N, M);
        start = 1'b1;
    endtask

    task automatic run_case(input logic [N-1:0] x, input logic [E_W-1:0] e,
                            input logic [N-1:0] res, input int mults, input bit poke);
        exp_t ent;
        int   d0;
        bit   ok;
        @(negedge clk);
        drive_op(x, e);
        ent.res   = res;
        ent.mults = mults;
        ent.lat   = mults * (lm + 1) + scan_cycles(e) + 1;
        ent.acc   = cyc;
        sb.push_back(ent);
        d0 = ndone;
        @(negedge clk);
        start = 1'b0;
        in_x  = '1;
        in_e  = '1;
        in_m  = '1;
        in_r  = '0;
        in_r2 = '0;
        if (poke) begin
            repeat (40) @(negedge clk);
            drive_op(2, 5);
            @(negedge clk);
            start = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge clk);
            if (ndone != d0) ok = 1'b1;
        end
        if (!ok) begin
            nchk++;
            $display("FAIL done_timeout: got no done expected done within 20000 cycles");
        end
    endtask

    initial begin
        int cnt;
        nchk = 0; npass = 0; ndone = 0; mm_starts = 0;
        lm = 5; stray = 1'b0; start = 1'b0; reset = 1'b1;
        in_x = '0; in_e = '0; in_m = '0; in_r = '0; in_r2 = '0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_done", N'(done), 0);
        chk("rst_busy", N'(busy), 0);
        chk("rst_mm_start", N'(mm_bus.mm_start), 0);
        chk("rst_mm_a", mm_bus.mm_a, 0);
        chk("rst_mm_b", mm_bus.mm_b, 0);
        chk("rst_mm_m", mm_bus.mm_m, 0);

        run_case(65, 17, 2790, 7, 1'b0);
        run_case(123, 0, 1, 2, 1'b0);
        run_case(2, 5, 32, 5, 1'b0);
        run_case(65, 17, 2790, 7, 1'b0);

        // Abort an operation partway through with a synchronous reset.
        @(negedge clk);
        drive_op(65, 17);
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5000 && cnt < 2; i++) begin
            @(negedge clk);
            if (mm_bus.mm_start) cnt++;
        end
        chk_int("abort_second_mm_start_seen", cnt, 2);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", N'(busy), 0);
        chk("abort_mm_start", N'(mm_bus.mm_start), 0);
        chk("abort_result", result, 0);
        chk("abort_done", N'(done), 0);
        chk("abort_mm_a", mm_bus.mm_a, 0);
        reset = 1'b0;
        run_case(65, 17, 2790, 7, 1'b0);

        // start while busy is ignored; a stray mm_done in IDLE changes nothing.
        run_case(65, 17, 2790, 7, 1'b1);
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_busy", N'(busy), 0);
        chk("stray_result", result, 2790);

        lm = 1;
        run_case(65, 17, 2790, 7, 1'b0);
        run_case(123, 0, 1, 2, 1'b0);
        run_case(2, 5, 32, 5, 1'b0);

        lm = 40;
        run_case(65, 17, 2790, 7, 1'b0);
        run_case(2, 5, 32, 5, 1'b0);

        repeat (5) @(negedge clk);
        chk_int("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/mont_modexp_ctrl.md
# mont_modexp_ctrl

Left-to-right binary modular exponentiation controller: result = x^e mod M. It is the initiator side of the Montgomery multiplier's start/done interface. It sequences Montgomery-domain conversion, square/multiply steps and final reduction by issuing operand pairs and collecting products. It sits between the RSA top-level and the 1024-bit Montgomery multiplier; the multiplier is instantiated beside it, not inside.

## Interface
- N, 1024, operand/modulus width (must match multiplier).
- E_W, 1024, exponent width.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  one-cycle request; sampled only in IDLE.
- in_x  in  N  base, x < M.
- in_e  in  E_W  exponent.
- in_m  in  N  odd modulus.
- in_r  in  N  R mod M, R = 2^N.
- in_r2  in  N  R^2 mod M.
- result  out  N  x^e mod M; registered, held until next accepted start.
- done  out  1  one-cycle pulse when result is updated.
- busy  out  1  high from accepted start through the done cycle.
- mm_start  out  1  one-cycle pulse to multiplier.
- mm_a, mm_b, mm_m  out  N  multiplier operands; stable from mm_start until mm_done.
- mm_result  in  N  product a·b·R^-1 mod M; valid only while mm_done=1.
- mm_done  in  1  one-cycle completion pulse.

## Operation
- States: IDLE, TO_MONT, SCAN, SQUARE, MULTIPLY, FROM_MONT, DONE.
- IDLE: on start, latch in_x, in_e, in_m, in_r, in_r2 into internal registers; load bit counter = E_W; go to TO_MONT. Inputs may change after the accept cycle.
- Each multiply state: first cycle drives mm_start=1 with operands; waits for mm_done; captures mm_result into the destination register in the mm_done cycle; transitions on the next edge.
- TO_MONT: xm = mont(x, R^2). Next: SCAN.
- SCAN: one cycle per step. If e_reg MSB = 1, set A = xm, shift e_reg left, decrement counter, go to SQUARE, or to FROM_MONT if counter becomes 0. Otherwise shift, decrement, stay. If counter reaches 0 with no set bit (e = 0), set A = in_r and go to FROM_MONT.
- SQUARE: A = mont(A, A). Then, if the current MSB of e_reg = 1, go to MULTIPLY. Otherwise shift, decrement, and go to SQUARE, or to FROM_MONT when the counter is 0.
- MULTIPLY: A = mont(A, xm). Then shift, decrement, and go to SQUARE, or to FROM_MONT when the counter is 0.
- FROM_MONT: A = mont(A, 1); result <= mm_result. Next: DONE.
- DONE: done=1 for one cycle. Next: IDLE.
- mm_m is always the latched M. The controller does no arithmetic of its own; all reduction is the multiplier's job.

## Timing
- Reset values: result=0, done=0, busy=0, mm_start=0, mm_a=mm_b=mm_m=0; state IDLE; counter 0.
- start outside IDLE is ignored (no queueing).
- mm_done outside a multiply state waiting for completion is ignored.
- mm_start is never reasserted before the matching mm_done.
- Multiplication count = 2 + (bits below the top set bit) + (popcount(e) − 1); for e = 0, the count is 2.
- With Lm = cycles from mm_start to mm_done inclusive, each multiplication occupies Lm+1 controller cycles.
- Latency (start accept → done) = 1 + mults·(Lm+1) + SCAN cycles + 1. SCAN cycles = leading zeros + 1, or E_W when e = 0.
- Reset mid-operation: next cycle IDLE, all outputs at reset values. The multiplier shares the same reset.

## Structure
- Shared package mont_pkg: N, E_W defaults, state enum, counter width $clog2(E_W+1).
- Sub-module exp_bit_scanner: E_W shift register plus down-counter. Ports: load, shift, msb, last (counter==1 on the shift).

## Test plan
- Behavioural multiplier model, Lm=5. Bench computes R and R^2 mod M for each case.
- M=3233, x=65, e=17 -> result 2790; exactly 7 mm_start pulses (1+4+1+1).
- M=3233, x=123, e=0 -> result 1 after 2 pulses. SCAN lasts E_W cycles.
- M=3233, x=2, e=0x5 -> result 32 after 5 pulses (TO_MONT, SQ, SQ, MUL, FROM_MONT).
- Reset asserted 3 cycles after the second mm_start -> next cycle busy=0, mm_start=0, result=0. A new start with x=65, e=17 then yields 2790.
- start pulsed while busy, plus a stray mm_done in IDLE -> no state change, no extra done. Exactly one done per accepted start.
- Multiplier latency changed to Lm=1 and Lm=40 -> identical results. Latency matches the formula exactly.
